// File: rtl/soc_clk_rst_ctrl_if.sv
// Bundles the external reset button, core halt request and the generated reset/enable strobes.
// The master side drives the requests; the slave side (the controller) drives the outputs.
interface soc_clk_rst_ctrl_if;
    logic ext_resn;
    logic core_halt;
    logic out_rst;
    logic uart_ce;
    logic vga_ce;
    logic core_ce;

    modport master (
        output ext_resn,
        output core_halt,
        input  out_rst,
        input  uart_ce,
        input  vga_ce,
        input  core_ce
    );

    modport slave (
        input  ext_resn,
        input  core_halt,
        output out_rst,
        output uart_ce,
        output vga_ce,
        output core_ce
    );
endinterface

// File: rtl/soc_clk_rst_ctrl.sv
// PLL-free clock/reset controller: stretched SoC reset, UART/VGA tick strobes and core clock-gate enable.
// Define SOC_CLKRST_EXT_SYNC_EN to add a 2-flop synchronizer ahead of the ext_resn register.
module soc_clk_rst_ctrl #(
    parameter int RESET_HOLD        = 16,
    parameter int VGA_DIVIDER       = 4,
    parameter int UART_PLL_DIVIDER  = 2,
    parameter int UART_POST_DIVIDER = 5
) (
    input  logic              i_clk,
    input  logic              i_res,
    soc_clk_rst_ctrl_if.slave io_bus
);

    localparam logic [31:0] UART_DIV = 32'(UART_PLL_DIVIDER * UART_POST_DIVIDER);

    localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam int VGA_W  = (VGA_DIVIDER > 1) ? $clog2(VGA_DIVIDER) : 1;
    localparam int UART_W = (UART_DIV > 32'd1) ? $clog2(UART_DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
    localparam logic [VGA_W-1:0]  VGA_LAST  = VGA_W'(VGA_DIVIDER - 1);
    localparam logic [UART_W-1:0] UART_LAST = UART_W'(UART_DIV - 32'd1);

    if (RESET_HOLD < 1) begin : g_errHold
        $error("soc_clk_rst_ctrl: RESET_HOLD must be >= 1");
    end
    if (VGA_DIVIDER < 1) begin : g_errVga
        $error("soc_clk_rst_ctrl: VGA_DIVIDER must be >= 1");
    end
    if (UART_PLL_DIVIDER < 1) begin : g_errUartPll
        $error("soc_clk_rst_ctrl: UART_PLL_DIVIDER must be >= 1");
    end
    if (UART_POST_DIVIDER < 1) begin : g_errUartPost
        $error("soc_clk_rst_ctrl: UART_POST_DIVIDER must be >= 1");
    end

    logic              r_extResnS;
    logic              r_outRst;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [VGA_W-1:0]  r_vgaCnt;
    logic              r_vgaCe;
    logic [UART_W-1:0] r_uartCnt;
    logic              r_uartCe;
    logic              r_coreCe;
    logic              w_req;

`ifdef SOC_CLKRST_EXT_SYNC_EN
    logic r_extSync1;
    logic r_extSync2;

    // The button is asynchronous to clk, so it is resolved through two flops first.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_extSync1 <= 1'b1;
            r_extSync2 <= 1'b1;
            r_extResnS <= 1'b1;
        end else begin
            r_extSync1 <= io_bus.ext_resn;
            r_extSync2 <= r_extSync1;
            r_extResnS <= r_extSync2;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_extResnS <= 1'b1;
        end else begin
            r_extResnS <= io_bus.ext_resn;
        end
    end
`endif

    assign w_req = i_res | ~r_extResnS;

    // Any new request reloads the full hold time, even mid-countdown.
    always_ff @(posedge i_clk) begin
        if (w_req) begin
            r_holdCnt <= HOLD_INIT;
            r_outRst  <= 1'b1;
        end else if (r_holdCnt != '0) begin
            r_holdCnt <= r_holdCnt - HOLD_W'(1);
            r_outRst  <= 1'b1;
        end else begin
            r_outRst  <= 1'b0;
        end
    end

    // Dividers see only res, so ext_resn resets never disturb the strobe phase.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_vgaCnt <= '0;
            r_vgaCe  <= 1'b0;
        end else if (r_vgaCnt == VGA_LAST) begin
            r_vgaCnt <= '0;
            r_vgaCe  <= 1'b1;
        end else begin
            r_vgaCnt <= r_vgaCnt + VGA_W'(1);
            r_vgaCe  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_uartCnt <= '0;
            r_uartCe  <= 1'b0;
        end else if (r_uartCnt == UART_LAST) begin
            r_uartCnt <= '0;
            r_uartCe  <= 1'b1;
        end else begin
            r_uartCnt <= r_uartCnt + UART_W'(1);
            r_uartCe  <= 1'b0;
        end
    end

    // The core clock must run while out_rst is high so the core sees its synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_coreCe <= 1'b0;
        end else if (r_outRst) begin
            r_coreCe <= 1'b1;
        end else begin
            r_coreCe <= ~io_bus.core_halt;
        end
    end

    assign io_bus.out_rst = r_outRst;
    assign io_bus.vga_ce  = r_vgaCe;
    assign io_bus.uart_ce = r_uartCe;
    assign io_bus.core_ce = r_coreCe;

endmodule

// File: tb/tb_soc_clk_rst_ctrl.sv
// Self-checking bench for soc_clk_rst_ctrl: directed scenarios then random res/ext_resn/core_halt,
// compared each cycle against an edge-history reference model; a second instance covers divide-by-1.
module tb_soc_clk_rst_ctrl;

    localparam int HOLD     = 16;
    localparam int VGA_DIV  = 4;
    localparam int UART_DIV = 10;
    localparam int MAXE     = 2000;
`ifdef SOC_CLKRST_EXT_SYNC_EN
    localparam int EXT_TAP = 3;
`else
    localparam int EXT_TAP = 1;
`endif

    logic clk;
    logic res;

    soc_clk_rst_ctrl_if busA ();
    soc_clk_rst_ctrl_if busB ();

    soc_clk_rst_ctrl #(
        .RESET_HOLD        (HOLD),
        .VGA_DIVIDER       (VGA_DIV),
        .UART_PLL_DIVIDER  (2),
        .UART_POST_DIVIDER (5)
    ) dutA (
        .i_clk  (clk),
        .i_res  (res),
        .io_bus (busA)
    );

    soc_clk_rst_ctrl #(
        .RESET_HOLD        (HOLD),
        .VGA_DIVIDER       (1),
        .UART_PLL_DIVIDER  (1),
        .UART_POST_DIVIDER (1)
    ) dutB (
        .i_clk  (clk),
        .i_res  (res),
        .io_bus (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int misc    = 0;
    int edgeNo  = 0;
    int lastReq = 0;
    int lastRes = 0;
    bit extHist [0:MAXE];
    bit resHist [0:MAXE];
    bit prevOut = 1'b1;
    bit expOut, expCore, expVga, expUart, expOne;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, edgeNo, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then check at the falling edge.
    task automatic applyStimulus(input bit r, input bit ext, input bit halt);
        bit req;
        bit blocked;
        res            = r;
        busA.ext_resn  = ext;
        busA.core_halt = halt;
        busB.ext_resn  = ext;
        busB.core_halt = halt;
        @(posedge clk);
        edgeNo++;
        extHist[edgeNo] = ext;
        resHist[edgeNo] = r;
        req = r;
        if (edgeNo - EXT_TAP >= 1) begin
            blocked = 1'b0;
            for (int k = edgeNo - EXT_TAP; k < edgeNo; k++) begin
                if (resHist[k]) blocked = 1'b1;
            end
            if (!blocked && !extHist[edgeNo - EXT_TAP]) req = 1'b1;
        end
        if (req) lastReq = edgeNo;
        if (r) lastRes = edgeNo;
        expOut  = ((edgeNo - lastReq) <= HOLD);
        expCore = r ? 1'b0 : (prevOut ? 1'b1 : !halt);
        expVga  = !r && (((edgeNo - lastRes) % VGA_DIV) == 0);
        expUart = !r && (((edgeNo - lastRes) % UART_DIV) == 0);
        expOne  = !r;
        prevOut = expOut;
        @(negedge clk);
        checkOutput("out_rst", busA.out_rst, expOut);
        checkOutput("core_ce", busA.core_ce, expCore);
        checkOutput("vga_ce",  busA.vga_ce,  expVga);
        checkOutput("uart_ce", busA.uart_ce, expUart);
        checkOutput("div1_vga_ce",  busB.vga_ce,  expOne);
        checkOutput("div1_uart_ce", busB.uart_ce, expOne);
    endtask

    initial begin
        res            = 1'b1;
        busA.ext_resn  = 1'b1;
        busA.core_halt = 1'b0;
        busB.ext_resn  = 1'b1;
        busB.core_halt = 1'b0;

        // Power-on reset, then release and watch the hold and the strobes.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Button pulse, then a second pulse mid-countdown.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Core halt window, then toggling halt every cycle.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'(i % 2));

        // Random traffic on all three inputs.
        for (int i = 0; i < 700; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          !($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
